// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer for the CPU front end.
//               Owns the program counter and keeps at most one fetch in
//               flight on a req/gnt + rvalid instruction-memory interface.
//               Each returned word lands in a one-entry valid/ready buffer
//               that feeds decode. Stall and branch redirect are applied
//               here, and a fetch made stale by a redirect is squashed.
// Ports       : clk, rst (sync, active-low)
//               stall, redirect, redirect_pc      - pipeline control
//               imem_req/addr/gnt/rvalid/rdata    - instruction memory
//               if_valid/inst/pc, if_ready        - decode handshake
//               pc                                - next fetch address
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_fetch_addr;  // address of the fetch in flight
  logic                r_discard;     // in-flight fetch was made stale by a redirect
  logic                r_if_valid;
  logic [DATA_W-1:0]   r_if_inst;
  logic [ADDR_W-1:0]   r_if_pc;

  logic                w_req;
  logic                w_transfer;

  // A new fetch may only be issued when the buffer will have room for its
  // result: either it is empty or decode is draining it this cycle.
  assign w_req      = (r_state == S_FETCH) && !stall && !redirect &&
                      (!r_if_valid || if_ready);
  assign w_transfer = r_if_valid && if_ready;

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_pc     = r_if_pc;
  assign pc        = r_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_fetch_addr <= '0;
      r_discard    <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_inst    <= '0;
      r_if_pc      <= '0;
    end else begin
      // Drain first; a reload later in this block overrides the clear.
      if (w_transfer) begin
        r_if_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end

        S_FETCH: begin
          if (redirect) begin
            r_pc       <= redirect_pc;
            r_if_valid <= 1'b0;
          end else if (w_req && imem_gnt) begin
            r_fetch_addr <= r_pc;
            r_pc         <= r_pc + c_PC_STEP;
            r_state      <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect) begin
            r_pc       <= redirect_pc;
            r_if_valid <= 1'b0;
            if (imem_rvalid) begin
              // Stale word arrives together with the redirect: drop it now.
              r_discard <= 1'b0;
              r_state   <= S_FETCH;
            end else begin
              r_discard <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (r_discard) begin
              r_discard <= 1'b0;
            end else begin
              r_if_inst  <= imem_rdata;
              r_if_pc    <= r_fetch_addr;
              r_if_valid <= 1'b1;
            end
            r_state <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl. Two instances
//               share all inputs; the second uses a reset PC at the top of
//               the address space so the PC wrap shows up on the same
//               stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int c_AW = 32;
  localparam int c_DW = 32;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            redirect;
  logic [c_AW-1:0] redirect_pc;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [c_DW-1:0] imem_rdata;
  logic            if_ready;

  logic            imem_req,  imem_req2;
  logic [c_AW-1:0] imem_addr, imem_addr2;
  logic            if_valid,  if_valid2;
  logic [c_DW-1:0] if_inst,   if_inst2;
  logic [c_AW-1:0] if_pc,     if_pc2;
  logic [c_AW-1:0] pc,        pc2;

  int n_cmp;
  int n_bad;

  fetch_ctrl #(.ADDR_W(c_AW), .DATA_W(c_DW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(if_ready), .pc(pc)
  );

  fetch_ctrl #(.ADDR_W(c_AW), .DATA_W(c_DW), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid2), .if_inst(if_inst2), .if_pc(if_pc2),
    .if_ready(if_ready), .pc(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 2 ns after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if_ready    = 1'b1;

    // ---- reset ----
    step();
    step();
    check("rst_req",      {63'd0, imem_req},  64'd0);
    check("rst_valid",    {63'd0, if_valid},  64'd0);
    check("rst_pc",       {32'd0, pc},        64'h0);
    check("rst_addr",     {32'd0, imem_addr}, 64'h0);
    check("rst_inst",     {32'd0, if_inst},   64'h0);
    check("rst_ifpc",     {32'd0, if_pc},     64'h0);
    check("rst_pc_wrap",  {32'd0, pc2},       64'hFFFF_FFFC);

    rst = 1'b1;
    #1;
    check("idle_req", {63'd0, imem_req}, 64'd0);
    step();                                   // IDLE -> FETCH
    check("first_req",       {63'd0, imem_req}, 64'd1);
    check("first_addr",      {32'd0, imem_addr}, 64'h0);
    check("first_addr_wrap", {32'd0, imem_addr2}, 64'hFFFF_FFFC);

    // ---- back-to-back fetches, gnt=1, rvalid one cycle after gnt ----
    imem_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();                                 // grant edge -> WAIT
      check($sformatf("wait_req_%0d", k),   {63'd0, imem_req}, 64'd0);
      check($sformatf("wait_valid_%0d", k), {63'd0, if_valid}, 64'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hC0DE_0000 + 32'(k);
      step();                                 // data lands in buffer
      imem_rvalid = 1'b0;
      check($sformatf("b2b_valid_%0d", k), {63'd0, if_valid}, 64'd1);
      check($sformatf("b2b_pc_%0d", k),    {32'd0, if_pc}, 64'(4 * k));
      check($sformatf("b2b_inst_%0d", k),  {32'd0, if_inst}, 64'(32'hC0DE_0000 + 32'(k)));
      check($sformatf("b2b_next_%0d", k),  {32'd0, imem_addr}, 64'(4 * (k + 1)));
      check($sformatf("b2b_req_%0d", k),   {63'd0, imem_req}, 64'd1);
    end
    check("wrap_pc0", {32'd0, dut_wrap.if_pc}, 64'h0000_0004);
    check("wrap_pc_seq", {32'd0, pc2}, 64'h0000_0008);

    // ---- decode back-pressure ----
    imem_gnt = 1'b0;
    if_ready = 1'b0;
    #1;
    check("bp_req0", {63'd0, imem_req}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_valid_%0d", k), {63'd0, if_valid}, 64'd1);
      check($sformatf("bp_inst_%0d", k),  {32'd0, if_inst}, 64'hC0DE_0002);
      check($sformatf("bp_pc_%0d", k),    {32'd0, if_pc}, 64'h8);
      check($sformatf("bp_req_%0d", k),   {63'd0, imem_req}, 64'd0);
    end
    if_ready = 1'b1;
    step();                                   // transfer
    check("bp_drain_valid", {63'd0, if_valid}, 64'd0);
    check("bp_new_req",     {63'd0, imem_req}, 64'd1);
    check("bp_new_addr",    {32'd0, imem_addr}, 64'hC);

    // ---- redirect while WAIT: stale word squashed ----
    imem_gnt = 1'b1;
    step();                                   // grant 0xC -> WAIT
    imem_gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();                                   // redirect, no rvalid -> discard
    redirect = 1'b0;
    check("rd_pc",  {32'd0, pc}, 64'h100);
    check("rd_req", {63'd0, imem_req}, 64'd0);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();                                   // stale data dropped
    imem_rvalid = 1'b0;
    check("rd_stale_valid", {63'd0, if_valid}, 64'd0);
    check("rd_req_after",   {63'd0, imem_req}, 64'd1);
    check("rd_addr_after",  {32'd0, imem_addr}, 64'h100);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    check("rd_new_valid", {63'd0, if_valid}, 64'd1);
    check("rd_new_pc",    {32'd0, if_pc}, 64'h100);
    check("rd_new_inst",  {32'd0, if_inst}, 64'h1111_1111);

    // ---- stall and redirect together ----
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    check("sr_req", {63'd0, imem_req}, 64'd0);
    step();
    redirect = 1'b0;
    check("sr_pc",    {32'd0, pc}, 64'h200);
    check("sr_valid", {63'd0, if_valid}, 64'd0);
    check("sr_req_stalled", {63'd0, imem_req}, 64'd0);
    step();
    check("sr_pc_hold", {32'd0, pc}, 64'h200);
    stall = 1'b0;
    #1;
    check("sr_req_release",  {63'd0, imem_req}, 64'd1);
    check("sr_addr_release", {32'd0, imem_addr}, 64'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
